reg_window_ctrl: RTL and testbench
==================================

// Module: reg_window_ctrl
// PURPOSE
//   Register-window controller for the windowed register file. Holds CWP (current window pointer) and WIM (window invalid mask).
//   Sequences SAVE/RESTORE with a req/done handshake and raises overflow/underflow traps.
//   Drives per-window RFE enables and block-enable decodes (BE3/BE2/BE1) into the array of window slices.
// PARAMETERS
//   NWIN   8   number of register windows (power of 2, 2..32)
//   CWP_W  3   width of CWP, = log2(NWIN)
// PORTS
//   Clk          in   1      system clock, all state on rising edge
//   Rst          in   1      synchronous reset, active-high
//   save_req     in   1      SAVE request, sampled only in IDLE
//   restore_req  in   1      RESTORE request, sampled only in IDLE
//   trap_ack     in   1      trap handler accepted trap; leaves TRAP
//   wim_we       in   1      write WIM from wim_in (idle only)
//   wim_in       in   NWIN   new WIM value
//   cwp_we       in   1      write CWP from cwp_in (idle only)
//   cwp_in       in   CWP_W  new CWP value
//   wr_addr      in   5      register write address (r0..r31 of current window)
//   cwp          out  CWP_W  current window pointer
//   wim          out  NWIN   window invalid mask
//   rfe          out  NWIN   one-hot window enable, = onehot(cwp) in IDLE, else all 0
//   be3,be2,be1  out  1      block enables: wr_addr[4:3]==00 / 01 / 10; 11 (globals) -> none
//   busy         out  1      high in any state but IDLE
//   done         out  1      one-cycle pulse when CWP update completes
//   ovf_trap     out  1      window overflow, held in TRAP until trap_ack
//   unf_trap     out  1      window underflow, held in TRAP until trap_ack
// BEHAVIOUR
//   Reset: cwp=0, wim=0, state=IDLE, done=ovf_trap=unf_trap=busy=0, rfe=0000_0001.
//   FSM IDLE -> EVAL -> (COMMIT | TRAP) -> IDLE.
//   IDLE: save_req wins over simultaneous restore_req; the request is latched as op and the FSM moves to EVAL.
//   IDLE: wim_we/cwp_we take effect at that edge. A request in the same cycle is evaluated against the new values.
//   EVAL: tgt = cwp-1 mod NWIN (SAVE) or cwp+1 mod NWIN (RESTORE). Wrap: 0-1 -> NWIN-1, NWIN-1+1 -> 0.
//   EVAL: if wim[tgt] then TRAP with ovf_trap (SAVE) or unf_trap (RESTORE) set, else COMMIT.
//   COMMIT: cwp<=tgt, done=1 for one cycle, then IDLE. Latency req -> done = 2 cycles; cwp new in cycle 3.
//   TRAP: cwp unchanged; trap flag held until trap_ack; cleared at that edge, then IDLE.
//   trap_ack outside TRAP is ignored.
//   Requests, wim_we and cwp_we outside IDLE are ignored (not queued). Requesters must hold or retry after busy falls.
//   rfe is forced to 0 while busy, which blocks register-file writes during a window change.
//   Rst asserted in any state returns to reset values next edge; a pending op is dropped and no done/trap is produced.
// CONFIGURATION
//   RWC_TRAP_CNT_EN defined: extra outputs ovf_cnt[15:0] and unf_cnt[15:0].
//     Each increments on entry to TRAP with the matching flag, saturates at 16'hFFFF and is cleared by Rst.
//   RWC_TRAP_CNT_EN undefined: counters and ports are absent; behaviour is otherwise identical.
// STRUCTURE
//   Package rwc_pkg: state encoding (IDLE=0, EVAL=1, COMMIT=2, TRAP=3), op encoding (OP_SAVE, OP_RESTORE),
//     default NWIN/CWP_W, block select constants (BLK_LOCAL=2'b00, BLK_IN=2'b01, BLK_OUT=2'b10, BLK_GLOBAL=2'b11).
//   Sub-module win_onehot_dec (CWP_W -> NWIN one-hot decoder), used for rfe.
//   FSM, wrap arithmetic and BE decode stay in this module.
// TESTING
//   Reset, then save_req 1 cycle with wim=0: done at cycle +2, cwp 0 -> 7, busy high 2 cycles, rfe=1000_0000 afterwards.
//   cwp=7, restore_req -> cwp=0 (wrap), done pulse; then restore_req with wim=0000_0010 -> unf_trap held, cwp=0 until trap_ack.
//   cwp=3, wim=0000_0100, save_req -> ovf_trap, cwp stays 3; trap_ack -> flag clears, busy=0 next cycle.
//   save_req and restore_req together with cwp=2 -> cwp=1 (SAVE wins); save_req in the same cycle as wim_we(0000_0010) -> ovf_trap.
//   Rst pulsed while in EVAL -> cwp=0, wim=0, no done/trap; save_req while busy ignored (cwp changes once only).
//   wr_addr=5'b01010 -> be2=1 only; 5'b11000 -> be3=be2=be1=0. With RWC_TRAP_CNT_EN: 3 overflows -> ovf_cnt=3.

Source files
------------

// File: rtl/rwc_pkg.sv
// Shared types and constants for the register-window controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rwc_pkg;

    // Default geometry: eight windows addressed by a 3-bit CWP.
    localparam int RWC_NWIN  = 8;
    localparam int RWC_CWP_W = 3;

    // Controller states; the encoding is fixed so it can be observed in debug.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        TRAP   = 2'd3
    } state_t;

    // Latched window operation.
    typedef enum logic {
        OP_SAVE    = 1'b0,
        OP_RESTORE = 1'b1
    } op_t;

    // Block select taken from wr_addr[4:3].
    localparam logic [1:0] BLK_LOCAL  = 2'b00;
    localparam logic [1:0] BLK_IN     = 2'b01;
    localparam logic [1:0] BLK_OUT    = 2'b10;
    localparam logic [1:0] BLK_GLOBAL = 2'b11;

    // Saturating 16-bit increment for the trap statistics counters.
    localparam logic [15:0] TRAP_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == TRAP_CNT_MAX) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/win_onehot_dec.sv
// Binary window index to one-hot window select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
module win_onehot_dec #(
    parameter int NWIN  = 8,
    parameter int CWP_W = 3
) (
    input  logic [CWP_W-1:0] sel,
    output logic [NWIN-1:0]  onehot
);

    // Exactly one bit set, at the position named by sel.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window controller: CWP/WIM state, SAVE/RESTORE sequencing, window traps, RFE/BE decode.
// Latency: request sampled in IDLE -> done pulse 2 cycles later, new CWP visible the cycle after.
// Backpressure: busy high outside IDLE; requests and CSR writes seen while busy are dropped, not queued.
// Optional feature macro RWC_TRAP_CNT_EN adds saturating ovf_cnt/unf_cnt trap statistics outputs.
module reg_window_ctrl
    import rwc_pkg::*;
#(
    parameter int NWIN  = RWC_NWIN,
    parameter int CWP_W = RWC_CWP_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             save_req,
    input  logic             restore_req,
    input  logic             trap_ack,
    input  logic             wim_we,
    input  logic [NWIN-1:0]  wim_in,
    input  logic             cwp_we,
    input  logic [CWP_W-1:0] cwp_in,
    input  logic [4:0]       wr_addr,
    output logic [CWP_W-1:0] cwp,
    output logic [NWIN-1:0]  wim,
    output logic [NWIN-1:0]  rfe,
    output logic             be3,
    output logic             be2,
    output logic             be1,
    output logic             busy,
    output logic             done,
    output logic             ovf_trap,
    output logic             unf_trap
`ifdef RWC_TRAP_CNT_EN
    ,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      unf_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    op_t              op;
    logic [CWP_W-1:0] cwp_q;
    logic [NWIN-1:0]  wim_q;
    logic [CWP_W-1:0] tgt;
    logic             tgt_invalid;
    logic             in_idle;
    logic             any_req;
    logic [NWIN-1:0]  win_sel;
    logic [1:0]       blk;

    assign in_idle = (state == IDLE);
    assign any_req = save_req | restore_req;

    // Target window: CWP arithmetic wraps naturally because NWIN is 2**CWP_W.
    assign tgt         = (op == OP_SAVE) ? (cwp_q - CWP_W'(1)) : (cwp_q + CWP_W'(1));
    assign tgt_invalid = wim_q[tgt];

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs; trap flags are a function of state and the latched op.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        ovf_trap  = 1'b0;
        unf_trap  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = tgt_invalid ? TRAP : COMMIT;
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            TRAP: begin
                ovf_trap = (op == OP_SAVE);
                unf_trap = (op == OP_RESTORE);
                if (trap_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // CWP, WIM and op latch; CSR writes land in IDLE so a same-cycle request sees them in EVAL.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cwp_q <= '0;
            wim_q <= '0;
            op    <= OP_SAVE;
        end else begin
            if (in_idle) begin
                if (wim_we) begin
                    wim_q <= wim_in;
                end
                if (cwp_we) begin
                    cwp_q <= cwp_in;
                end
                if (save_req) begin
                    op <= OP_SAVE;
                end else if (restore_req) begin
                    op <= OP_RESTORE;
                end
            end else if (state == COMMIT) begin
                cwp_q <= tgt;
            end
        end
    end

`ifdef RWC_TRAP_CNT_EN
    logic trap_entry;

    assign trap_entry = (state == EVAL) && tgt_invalid;

    // Trap statistics: count each entry into TRAP by kind, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (trap_entry) begin
            if (op == OP_SAVE) begin
                ovf_cnt <= sat_inc16(ovf_cnt);
            end else begin
                unf_cnt <= sat_inc16(unf_cnt);
            end
        end
    end
`endif

    win_onehot_dec #(
        .NWIN  (NWIN),
        .CWP_W (CWP_W)
    ) u_win_dec (
        .sel    (cwp_q),
        .onehot (win_sel)
    );

    // Window enables are gated off during a window change so no write lands in a stale window.
    always_comb begin
        rfe = in_idle ? win_sel : '0;
    end

    // Block enables from the register address; globals select none of the window blocks.
    assign blk = wr_addr[4:3];

    always_comb begin
        be3 = (blk == BLK_LOCAL);
        be2 = (blk == BLK_IN);
        be1 = (blk == BLK_OUT);
    end

    assign cwp = cwp_q;
    assign wim = wim_q;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Directed bench for reg_window_ctrl with a scoreboard of expected done/trap events.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: expected events are queued at stimulus time and popped when the DUT reports one.
module tb_reg_window_ctrl;

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_UNF  = 3'b010;
    localparam logic [2:0] K_OVF  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] cwp;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       save_req;
    logic       restore_req;
    logic       trap_ack;
    logic       wim_we;
    logic [7:0] wim_in;
    logic       cwp_we;
    logic [2:0] cwp_in;
    logic [4:0] wr_addr;
    logic [2:0] cwp;
    logic [7:0] wim;
    logic [7:0] rfe;
    logic       be3;
    logic       be2;
    logic       be1;
    logic       busy;
    logic       done;
    logic       ovf_trap;
    logic       unf_trap;
`ifdef RWC_TRAP_CNT_EN
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    reg_window_ctrl dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .save_req    (save_req),
        .restore_req (restore_req),
        .trap_ack    (trap_ack),
        .wim_we      (wim_we),
        .wim_in      (wim_in),
        .cwp_we      (cwp_we),
        .cwp_in      (cwp_in),
        .wr_addr     (wr_addr),
        .cwp         (cwp),
        .wim         (wim),
        .rfe         (rfe),
        .be3         (be3),
        .be2         (be2),
        .be1         (be1),
        .busy        (busy),
        .done        (done),
        .ovf_trap    (ovf_trap),
        .unf_trap    (unf_trap)
`ifdef RWC_TRAP_CNT_EN
        ,
        .ovf_cnt     (ovf_cnt),
        .unf_cnt     (unf_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        save_req    = 1'b0;
        restore_req = 1'b0;
        wim_we      = 1'b0;
        cwp_we      = 1'b0;
    endtask

    // Pop the next expected event, wait (bounded) for the DUT to report one, and compare.
    task automatic wait_out(input string tag, input bit hold);
        exp_t e;
        int   cyc;
        bit   got;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        e   = sb.pop_front();
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            step();
            cyc++;
            if (!hold) clear_inputs();
            if (cyc == 1) begin
                chk({tag, "_busy_eval"}, 32'(busy), 32'd1);
                chk({tag, "_rfe_eval"}, 32'(rfe), 32'd0);
            end
            if (done || ovf_trap || unf_trap) got = 1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd2);
        chk({tag, "_kind"}, 32'({ovf_trap, unf_trap, done}), 32'(e.kind));
        if (e.kind == K_DONE) begin
            step();
            clear_inputs();
            chk({tag, "_cwp"}, 32'(cwp), 32'(e.cwp));
            chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
        end else begin
            chk({tag, "_cwp_trap"}, 32'(cwp), 32'(e.cwp));
            repeat (3) step();
            clear_inputs();
            chk({tag, "_held"}, 32'({ovf_trap, unf_trap, done, busy}), 32'({e.kind, 1'b1}));
            trap_ack = 1'b1;
            step();
            trap_ack = 1'b0;
            chk({tag, "_ack"}, 32'({ovf_trap, unf_trap, done, busy}), 32'd0);
            chk({tag, "_cwp_after"}, 32'(cwp), 32'(e.cwp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seen;

        Rst      = 1'b1;
        trap_ack = 1'b0;
        wim_in   = '0;
        cwp_in   = '0;
        wr_addr  = '0;
        clear_inputs();
        step();
        step();
        chk("rst_cwp", 32'(cwp), 32'd0);
        chk("rst_wim", 32'(wim), 32'd0);
        chk("rst_rfe", 32'(rfe), 32'h01);
        chk("rst_flags", 32'({busy, done, ovf_trap, unf_trap}), 32'd0);
        Rst = 1'b0;
        step();

        // SAVE from window 0 wraps to 7.
        save_req = 1'b1;
        sb.push_back('{kind: K_DONE, cwp: 8'd7});
        wait_out("save_wrap", 1'b0);
        chk("save_rfe", 32'(rfe), 32'h80);

        // RESTORE from window 7 wraps to 0.
        restore_req = 1'b1;
        sb.push_back('{kind: K_DONE, cwp: 8'd0});
        wait_out("restore_wrap", 1'b0);
        chk("restore_rfe", 32'(rfe), 32'h01);

        // RESTORE into an invalid window 1 -> underflow.
        wim_we = 1'b1;
        wim_in = 8'b0000_0010;
        step();
        clear_inputs();
        chk("wim_write", 32'(wim), 32'h02);
        restore_req = 1'b1;
        sb.push_back('{kind: K_UNF, cwp: 8'd0});
        wait_out("unf", 1'b0);

        // SAVE from 3 into invalid window 2 -> overflow.
        cwp_we = 1'b1;
        cwp_in = 3'd3;
        wim_we = 1'b1;
        wim_in = 8'b0000_0100;
        step();
        clear_inputs();
        chk("cwp_write", 32'(cwp), 32'd3);
        save_req = 1'b1;
        sb.push_back('{kind: K_OVF, cwp: 8'd3});
        wait_out("ovf", 1'b0);

        // Simultaneous requests: SAVE wins.
        cwp_we = 1'b1;
        cwp_in = 3'd2;
        wim_we = 1'b1;
        wim_in = 8'h00;
        step();
        clear_inputs();
        save_req    = 1'b1;
        restore_req = 1'b1;
        sb.push_back('{kind: K_DONE, cwp: 8'd1});
        wait_out("save_wins", 1'b0);

        // CSR writes in the request cycle are seen by the evaluation.
        cwp_we   = 1'b1;
        cwp_in   = 3'd2;
        wim_we   = 1'b1;
        wim_in   = 8'b0000_0010;
        save_req = 1'b1;
        sb.push_back('{kind: K_OVF, cwp: 8'd2});
        wait_out("same_cycle_wim", 1'b0);

        // trap_ack outside TRAP does nothing.
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        chk("stray_ack", 32'({busy, ovf_trap, unf_trap, cwp}), 32'd2);

        // Reset while in EVAL drops the operation.
        cwp_we = 1'b1;
        cwp_in = 3'd5;
        wim_we = 1'b1;
        wim_in = 8'h10;
        step();
        clear_inputs();
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("mid_rst_cwp", 32'(cwp), 32'd0);
        chk("mid_rst_wim", 32'(wim), 32'd0);
        chk("mid_rst_rfe", 32'({busy, rfe}), 32'h01);
`ifdef RWC_TRAP_CNT_EN
        chk("cnt_rst", 32'({ovf_cnt, unf_cnt}), 32'd0);
`endif
        seen = '0;
        repeat (4) begin
            step();
            seen = seen | {ovf_trap, unf_trap, done};
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);

        // SAVE held high through the whole operation takes effect once.
        save_req = 1'b1;
        sb.push_back('{kind: K_DONE, cwp: 8'd7});
        wait_out("held_req", 1'b1);
        repeat (3) step();
        chk("held_once", 32'({busy, cwp}), 32'd7);

        // Block-enable decode.
        wr_addr = 5'b01010;
        #1;
        chk("be_in", 32'({be3, be2, be1}), 32'b010);
        wr_addr = 5'b11000;
        #1;
        chk("be_global", 32'({be3, be2, be1}), 32'b000);
        wr_addr = 5'b00111;
        #1;
        chk("be_local", 32'({be3, be2, be1}), 32'b100);
        wr_addr = 5'b10001;
        #1;
        chk("be_out", 32'({be3, be2, be1}), 32'b001);
        step();

        // Three overflows from window 7 into invalid window 6.
        wim_we = 1'b1;
        wim_in = 8'h40;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            save_req = 1'b1;
            sb.push_back('{kind: K_OVF, cwp: 8'd7});
            wait_out("ovf_rep", 1'b0);
        end
`ifdef RWC_TRAP_CNT_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'd3);
        chk("unf_cnt", 32'(unf_cnt), 32'd0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
